// File: rtl/packed_array_pkg.sv
// Shared types and helpers for blocks that walk lanes of a packed word.
package packed_array_pkg;

    // Default geometry: lanes per word and bits per lane.
    localparam int unsigned PA_WA = 8;
    localparam int unsigned PA_WB = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    typedef logic [PA_WB-1:0]            lane_t;
    typedef logic [PA_WA-1:0][PA_WB-1:0] word_t;

    // Maps beat number cnt to a lane index: ascending from 0 or descending from wa-1.
    function automatic int unsigned lane_index(input int unsigned cnt,
                                               input logic        dir,
                                               input int unsigned wa);
        return dir ? (wa - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/packed_lane_mux.sv
// Combinational selection of one lane from a packed word.
module packed_lane_mux #(
    parameter int unsigned WA = 8,
    parameter int unsigned WB = 8
) (
    input  logic [WA-1:0][WB-1:0]   word_i,
    input  logic [$clog2(WA)-1:0]   idx_i,
    output logic [WB-1:0]           lane_o
);

    assign lane_o = word_i[idx_i];

endmodule

// File: rtl/packed_lane_sequencer.sv
// Emits a captured packed word one lane per accepted beat, ascending or
// descending, for len+1 lanes. Handshakes on both sides are valid/ready:
// a transfer happens on the rising edge where valid and ready are both high;
// a held valid keeps its payload stable until that edge.
module packed_lane_sequencer
    import packed_array_pkg::*;
#(
    parameter int unsigned WA = 8,
    parameter int unsigned WB = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [WA-1:0][WB-1:0]   s_data,
    input  logic                    s_dir,
    input  logic [$clog2(WA)-1:0]   s_len,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WB-1:0]           m_data,
    output logic [$clog2(WA)-1:0]   m_idx,
    output logic                    m_last,
    output logic                    busy
);

    localparam int unsigned IW = $clog2(WA);

    state_e                 state_q, state_d;
    logic [IW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          len_q, len_d;
    logic                   dir_q, dir_d;
    logic [WA-1:0][WB-1:0]  buf_q, buf_d;

    logic [IW-1:0]          lane_idx;
    logic [WB-1:0]          lane_val;
    logic                   sending;
    logic                   at_last;
    logic                   capture;

    assign sending  = (state_q == SEND);
    assign at_last  = (cnt_q == len_q);
    assign lane_idx = IW'(lane_index(32'(cnt_q), dir_q, WA));

    packed_lane_mux #(
        .WA (WA),
        .WB (WB)
    ) u_mux (
        .word_i (buf_q),
        .idx_i  (lane_idx),
        .lane_o (lane_val)
    );

    // Outputs come only from registered buffer, counter and config; forced to
    // zero outside SEND so an idle block presents a clean bus.
    always_comb begin
        m_valid = sending;
        m_last  = sending & at_last;
        m_idx   = sending ? lane_idx : '0;
        m_data  = sending ? lane_val : '0;
        busy    = sending;
        // A new word may enter while the final lane of the current one leaves.
        s_ready = !sending | (m_ready & at_last);
        capture = s_valid & s_ready;
    end

    // Next-state: word capture, beat counting and return to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        dir_d   = dir_q;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    len_d   = s_len;
                    dir_d   = s_dir;
                    buf_d   = s_data;
                end
            end
            SEND: begin
                if (m_ready) begin
                    if (!at_last) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (capture) begin
                        cnt_d = '0;
                        len_d = s_len;
                        dir_d = s_dir;
                        buf_d = s_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, config and word buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            dir_q   <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            dir_q   <= dir_d;
            buf_q   <= buf_d;
        end
    end

endmodule
